race_timer_ctrl: RTL and testbench
==================================

// Module: race_timer_ctrl
// PURPOSE
//   Controller for the two-digit decimal display counter. Generates the count tick
//   from CLOCK_50 at a selectable rate and sequences the ones/tens BCD digits
//   through start/pause/resume/clear. Supports up or down counting and flags the
//   terminal value. Sits between the game FSM and the two seg7decoder instances.
// PARAMETERS
//   CLK_HZ  50_000_000  clock frequency; sets the divider reload values
//   DIV_W   28          divider width; must hold 2*CLK_HZ-1
//   LIMIT   8'h99       terminal value, BCD {tens,ones}; both nibbles must be 0-9
// PORTS
//   CLOCK_50  in   1  system clock; all state updates on the rising edge
//   resetn    in   1  asynchronous, active-low reset
//   start     in   1  start, or resume from PAUSED, or restart from DONE (level, sampled each cycle)
//   pause     in   1  pause while RUN (level)
//   clear     in   1  return to IDLE and reload the preset
//   rate      in   2  tick period: 00=1 cyc, 01=CLK_HZ/2, 10=CLK_HZ, 11=2*CLK_HZ
//   down      in   1  0=count up 00->LIMIT, 1=count down LIMIT->00; sampled only in IDLE
//   ones      out  4  BCD ones digit, registered
//   tens      out  4  BCD tens digit, registered
//   tick      out  1  one-cycle pulse, coincident with each digit update
//   running   out  1  high in RUN
//   done      out  1  high in DONE
// BEHAVIOUR
//   Reset: state=IDLE, divider=0, tick=0, running=0, done=0, {tens,ones}=8'h00.
//   States: IDLE, RUN, PAUSED, DONE. Command priority: clear > start > pause.
//   Preset value: 00 when counting up; LIMIT when counting down (dir latched from down).
//   IDLE: digits show the preset. start -> RUN; divider cleared.
//   RUN: divider counts 0..N-1, where N is the rate period.
//     When divider==N-1: divider<=0, tick<=1, digits step in the same edge.
//     rate=00 gives a tick every cycle.
//     Up step: ones 9->0 with tens+1; otherwise ones+1.
//     Down step: ones 0->9 with tens-1; otherwise ones-1.
//     After the step, if digits==target (LIMIT up, 00 down) -> DONE in the same edge.
//     pause -> PAUSED. Divider and digits hold; no tick.
//   PAUSED: everything holds. start -> RUN; divider resumes from its held value
//     (phase kept).
//   DONE: digits hold the target; done=1. start -> reload preset, clear divider, RUN.
//   clear in any state -> IDLE: digits<=preset (new down value), divider<=0, tick<=0.
//   Rate change: if rate differs from its previous-cycle value, divider<=0 that
//     cycle. No tick is issued on that cycle.
//   Latency: start at edge k -> running=1 after edge k. First tick N cycles later.
//   Outputs are registered. done/running are decoded from the state register.
//   Invariant: ones and tens are always 0-9. Values 10-15 are never produced.
//   LIMIT==8'h00: a start goes directly to DONE on the first tick.
//   resetn low mid-run: immediate async return to the reset values.
// TESTING  (bench uses CLK_HZ=8, so N = 1/4/8/16 cycles)
//   rate=00, up, start held 1 cycle -> tick every cycle; 00,01,..,09,10,..,99;
//     done=1 at 99, tick stops.
//   rate=10, up -> first tick exactly 8 cycles after start; ones 9 -> tens+1, ones=0.
//   down=1, LIMIT=8'h25 -> IDLE shows 25; run: 25,24,..,20,19,..,00; done; start restarts at 25.
//   pause at divider=5 (rate=10), hold 20 cycles, start -> next tick 3 cycles later.
//   clear+start same cycle in RUN -> IDLE with preset. rate change mid-run -> divider=0, period restarts.
//   resetn pulsed low mid-count (async, between edges) -> all outputs 0 immediately; state IDLE.

Source files
------------

// File: rtl/race_timer_if.sv
// Command and display bundle between the game FSM (master) and the
// two-digit race timer controller (slave).
interface race_timer_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic [1:0] rate;
  logic       down;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       tick;
  logic       running;
  logic       done;

  modport master (
    output start, pause, clear, rate, down,
    input  ones, tens, tick, running, done
  );

  modport slave (
    input  start, pause, clear, rate, down,
    output ones, tens, tick, running, done
  );
endinterface

// File: rtl/race_timer_ctrl.sv
// Two-digit BCD race timer: rate-selectable tick divider plus an
// IDLE/RUN/PAUSED/DONE sequencer that counts up to LIMIT or down to 00.
module race_timer_ctrl #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DIV_W  = 28,
  parameter logic [7:0]  LIMIT  = 8'h99
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  race_timer_if.slave  io_bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic [DIV_W-1:0] DivMaxHalf = DIV_W'(CLK_HZ / 2 - 1);
  localparam logic [DIV_W-1:0] DivMaxOne  = DIV_W'(CLK_HZ - 1);
  localparam logic [DIV_W-1:0] DivMaxTwo  = DIV_W'(2 * CLK_HZ - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic [DIV_W-1:0] w_div_max;
  logic [3:0]       r_ones;
  logic [3:0]       r_tens;
  logic [3:0]       w_ones_next;
  logic [3:0]       w_tens_next;
  logic [3:0]       w_step_ones;
  logic [3:0]       w_step_tens;
  logic             r_tick;
  logic             r_dir;
  logic             w_dir_next;
  logic [1:0]       r_rate_prev;
  logic [7:0]       w_preset_in;
  logic [7:0]       w_preset_dir;
  logic [7:0]       w_target;
  logic             w_at_target;
  logic             w_step_hit;
  logic             w_rate_chg;
  logic             w_run_go;
  logic             w_fire;
  logic             w_running;
  logic             w_done;

  // Terminal divider value for the selected tick period
  always_comb begin
    case (io_bus.rate)
      2'b00:   w_div_max = '0;
      2'b01:   w_div_max = DivMaxHalf;
      2'b10:   w_div_max = DivMaxOne;
      default: w_div_max = DivMaxTwo;
    endcase
  end

  always_comb begin
    w_preset_in  = io_bus.down ? LIMIT : 8'h00;
    w_preset_dir = r_dir ? LIMIT : 8'h00;
    w_target     = r_dir ? 8'h00 : LIMIT;
    w_at_target  = ({r_tens, r_ones} == w_target);
    w_rate_chg   = (io_bus.rate != r_rate_prev);
    // start outranks pause, so a held start keeps the count going
    w_run_go     = (r_state == StRun) && !io_bus.clear && (io_bus.start || !io_bus.pause);
    w_fire       = w_run_go && !w_rate_chg && (r_div == w_div_max);
  end

  // BCD increment/decrement; digit wraps keep both nibbles within 0-9
  always_comb begin
    w_step_ones = r_ones;
    w_step_tens = r_tens;
    if (!r_dir) begin
      if (r_ones >= 4'd9) begin
        w_step_ones = 4'd0;
        w_step_tens = (r_tens >= 4'd9) ? 4'd0 : r_tens + 4'd1;
      end else begin
        w_step_ones = r_ones + 4'd1;
      end
    end else begin
      if (r_ones == 4'd0) begin
        w_step_ones = 4'd9;
        w_step_tens = (r_tens == 4'd0) ? 4'd9 : r_tens - 4'd1;
      end else begin
        w_step_ones = r_ones - 4'd1;
      end
    end
    w_step_hit = ({w_step_tens, w_step_ones} == w_target);
  end

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (io_bus.clear) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (io_bus.start) w_state_next = StRun;
        end
        StRun: begin
          if (!io_bus.start && io_bus.pause) begin
            w_state_next = StPaused;
          end else if (w_fire && (w_at_target || w_step_hit)) begin
            w_state_next = StDone;
          end
        end
        StPaused: begin
          if (io_bus.start) w_state_next = StRun;
        end
        StDone: begin
          if (io_bus.start) w_state_next = StRun;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Output decode from the state register
  always_comb begin
    w_running = (r_state == StRun);
    w_done    = (r_state == StDone);
  end

  // Divider, digit and direction next-state
  always_comb begin
    w_div_next  = r_div;
    w_ones_next = r_ones;
    w_tens_next = r_tens;
    w_dir_next  = r_dir;
    if (io_bus.clear || (r_state == StIdle)) begin
      w_div_next                 = '0;
      {w_tens_next, w_ones_next} = w_preset_in;
      w_dir_next                 = io_bus.down;
    end else if (r_state == StDone) begin
      w_div_next = '0;
      if (io_bus.start) {w_tens_next, w_ones_next} = w_preset_dir;
    end else if (w_rate_chg) begin
      w_div_next = '0;
    end else if (w_fire) begin
      w_div_next = '0;
      // A preset already equal to the target finishes without stepping
      if (!w_at_target) {w_tens_next, w_ones_next} = {w_step_tens, w_step_ones};
    end else if (w_run_go) begin
      w_div_next = r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_div       <= '0;
      r_ones      <= 4'd0;
      r_tens      <= 4'd0;
      r_tick      <= 1'b0;
      r_dir       <= 1'b0;
      r_rate_prev <= 2'b00;
    end else begin
      r_div       <= w_div_next;
      r_ones      <= w_ones_next;
      r_tens      <= w_tens_next;
      r_tick      <= w_fire;
      r_dir       <= w_dir_next;
      r_rate_prev <= io_bus.rate;
    end
  end

  assign io_bus.ones    = r_ones;
  assign io_bus.tens    = r_tens;
  assign io_bus.tick    = r_tick;
  assign io_bus.running = w_running;
  assign io_bus.done    = w_done;

endmodule

// File: tb/tb_race_timer_ctrl.sv
// Directed bench for race_timer_ctrl: an up counter (LIMIT 99) and a down
// counter (LIMIT 25), both at CLK_HZ=8 so the tick periods are 1/4/8/16 cycles.
module tb_race_timer_ctrl;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  race_timer_if bus_up ();
  race_timer_if bus_dn ();

  race_timer_ctrl #(.CLK_HZ(8), .DIV_W(5), .LIMIT(8'h99)) u_dut_up (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .io_bus   (bus_up)
  );

  race_timer_ctrl #(.CLK_HZ(8), .DIV_W(5), .LIMIT(8'h25)) u_dut_dn (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .io_bus   (bus_dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #12;
    n_tests++;
    if ({bus_up.tens, bus_up.ones} !== 8'h00) begin
      n_fail++; $display("FAIL reset_digits got %h want 00", {bus_up.tens, bus_up.ones});
    end
    n_tests++;
    if ({bus_up.tick, bus_up.running, bus_up.done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {bus_up.tick, bus_up.running, bus_up.done});
    end
    n_tests++;
    if ({bus_dn.tens, bus_dn.ones, bus_dn.tick, bus_dn.running, bus_dn.done} !== 11'd0) begin
      n_fail++; $display("FAIL reset_dn got %h want 0", {bus_dn.tens, bus_dn.ones});
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(2);
  endtask

  task automatic test_down;
    n_tests++;
    if ({bus_dn.tens, bus_dn.ones} !== 8'h25) begin
      n_fail++; $display("FAIL down_idle_preset got %h want 25", {bus_dn.tens, bus_dn.ones});
    end
    bus_dn.start = 1'b1;
    cyc(1);
    bus_dn.start = 1'b0;
    n_tests++;
    if ({bus_dn.running, bus_dn.tens, bus_dn.ones} !== {1'b1, 8'h25}) begin
      n_fail++; $display("FAIL down_start got run=%b %h want run=1 25", bus_dn.running,
                         {bus_dn.tens, bus_dn.ones});
    end
    for (int i = 1; i <= 25; i++) begin
      cyc(1);
      n_tests++;
      if ({bus_dn.tick, bus_dn.tens, bus_dn.ones} !== {1'b1, bcd(25 - i)}) begin
        n_fail++; $display("FAIL down_step%0d got tick=%b %h want tick=1 %h", i, bus_dn.tick,
                           {bus_dn.tens, bus_dn.ones}, bcd(25 - i));
      end
    end
    n_tests++;
    if ({bus_dn.done, bus_dn.running} !== 2'b10) begin
      n_fail++; $display("FAIL down_done got done=%b run=%b want 1 0", bus_dn.done, bus_dn.running);
    end
    cyc(1);
    n_tests++;
    if ({bus_dn.tick, bus_dn.done, bus_dn.tens, bus_dn.ones} !== {2'b01, 8'h00}) begin
      n_fail++; $display("FAIL down_hold got tick=%b done=%b %h want 0 1 00", bus_dn.tick,
                         bus_dn.done, {bus_dn.tens, bus_dn.ones});
    end
    bus_dn.start = 1'b1;
    cyc(1);
    bus_dn.start = 1'b0;
    n_tests++;
    if ({bus_dn.running, bus_dn.done, bus_dn.tens, bus_dn.ones} !== {2'b10, 8'h25}) begin
      n_fail++; $display("FAIL down_restart got run=%b done=%b %h want 1 0 25", bus_dn.running,
                         bus_dn.done, {bus_dn.tens, bus_dn.ones});
    end
    cyc(1);
    n_tests++;
    if ({bus_dn.tick, bus_dn.tens, bus_dn.ones} !== {1'b1, 8'h24}) begin
      n_fail++; $display("FAIL down_restart_step got tick=%b %h want 1 24", bus_dn.tick,
                         {bus_dn.tens, bus_dn.ones});
    end
  endtask

  task automatic test_up_fast;
    bus_up.start = 1'b1;
    cyc(1);
    bus_up.start = 1'b0;
    n_tests++;
    if ({bus_up.running, bus_up.tick, bus_up.tens, bus_up.ones} !== {2'b10, 8'h00}) begin
      n_fail++; $display("FAIL up_start got run=%b tick=%b %h want 1 0 00", bus_up.running,
                         bus_up.tick, {bus_up.tens, bus_up.ones});
    end
    for (int v = 1; v <= 99; v++) begin
      cyc(1);
      n_tests++;
      if ({bus_up.tick, bus_up.tens, bus_up.ones} !== {1'b1, bcd(v)}) begin
        n_fail++; $display("FAIL up_step%0d got tick=%b %h want tick=1 %h", v, bus_up.tick,
                           {bus_up.tens, bus_up.ones}, bcd(v));
      end
    end
    n_tests++;
    if ({bus_up.done, bus_up.running} !== 2'b10) begin
      n_fail++; $display("FAIL up_done got done=%b run=%b want 1 0", bus_up.done, bus_up.running);
    end
    cyc(3);
    n_tests++;
    if ({bus_up.tick, bus_up.done, bus_up.tens, bus_up.ones} !== {2'b01, 8'h99}) begin
      n_fail++; $display("FAIL up_hold got tick=%b done=%b %h want 0 1 99", bus_up.tick,
                         bus_up.done, {bus_up.tens, bus_up.ones});
    end
  endtask

  task automatic test_rate_slow;
    logic exp_tick;
    bus_up.rate  = 2'b10;
    bus_up.clear = 1'b1;
    cyc(1);
    bus_up.clear = 1'b0;
    n_tests++;
    if ({bus_up.done, bus_up.running, bus_up.tens, bus_up.ones} !== {2'b00, 8'h00}) begin
      n_fail++; $display("FAIL clear_from_done got done=%b run=%b %h want 0 0 00", bus_up.done,
                         bus_up.running, {bus_up.tens, bus_up.ones});
    end
    cyc(1);
    bus_up.start = 1'b1;
    cyc(1);
    bus_up.start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      cyc(1);
      exp_tick = ((c % 8) == 0);
      n_tests++;
      if ({bus_up.tick, bus_up.tens, bus_up.ones} !== {exp_tick, bcd(c / 8)}) begin
        n_fail++; $display("FAIL slow_cyc%0d got tick=%b %h want tick=%b %h", c, bus_up.tick,
                           {bus_up.tens, bus_up.ones}, exp_tick, bcd(c / 8));
      end
    end
  endtask

  task automatic test_pause;
    cyc(5);
    bus_up.pause = 1'b1;
    cyc(1);
    bus_up.pause = 1'b0;
    n_tests++;
    if (bus_up.running !== 1'b0) begin
      n_fail++; $display("FAIL pause_enter got run=%b want 0", bus_up.running);
    end
    for (int i = 0; i < 19; i++) begin
      cyc(1);
      n_tests++;
      if ({bus_up.tick, bus_up.running, bus_up.tens, bus_up.ones} !== {2'b00, 8'h10}) begin
        n_fail++; $display("FAIL pause_hold%0d got tick=%b run=%b %h want 0 0 10", i, bus_up.tick,
                           bus_up.running, {bus_up.tens, bus_up.ones});
      end
    end
    bus_up.start = 1'b1;
    cyc(1);
    bus_up.start = 1'b0;
    n_tests++;
    if ({bus_up.running, bus_up.tick} !== 2'b10) begin
      n_fail++; $display("FAIL resume got run=%b tick=%b want 1 0", bus_up.running, bus_up.tick);
    end
    cyc(2);
    n_tests++;
    if (bus_up.tick !== 1'b0) begin
      n_fail++; $display("FAIL resume_early got tick=%b want 0", bus_up.tick);
    end
    cyc(1);
    n_tests++;
    if ({bus_up.tick, bus_up.tens, bus_up.ones} !== {1'b1, 8'h11}) begin
      n_fail++; $display("FAIL resume_phase got tick=%b %h want 1 11", bus_up.tick,
                         {bus_up.tens, bus_up.ones});
    end
  endtask

  task automatic test_clear_and_rate;
    bus_up.clear = 1'b1;
    bus_up.start = 1'b1;
    cyc(1);
    bus_up.clear = 1'b0;
    bus_up.start = 1'b0;
    n_tests++;
    if ({bus_up.running, bus_up.done, bus_up.tick, bus_up.tens, bus_up.ones} !== {3'b000, 8'h00})
    begin
      n_fail++; $display("FAIL clear_start got run=%b tick=%b %h want 0 0 00", bus_up.running,
                         bus_up.tick, {bus_up.tens, bus_up.ones});
    end
    bus_up.start = 1'b1;
    cyc(1);
    bus_up.start = 1'b0;
    cyc(3);
    bus_up.rate = 2'b01;
    cyc(1);
    n_tests++;
    if ({bus_up.tick, bus_up.tens, bus_up.ones} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL rate_chg_edge got tick=%b %h want 0 00", bus_up.tick,
                         {bus_up.tens, bus_up.ones});
    end
    cyc(3);
    n_tests++;
    if (bus_up.tick !== 1'b0) begin
      n_fail++; $display("FAIL rate_chg_early got tick=%b want 0", bus_up.tick);
    end
    cyc(1);
    n_tests++;
    if ({bus_up.tick, bus_up.tens, bus_up.ones} !== {1'b1, 8'h01}) begin
      n_fail++; $display("FAIL rate_chg_period got tick=%b %h want 1 01", bus_up.tick,
                         {bus_up.tens, bus_up.ones});
    end
  endtask

  task automatic test_async_reset;
    bus_up.rate  = 2'b00;
    bus_up.clear = 1'b1;
    cyc(1);
    bus_up.clear = 1'b0;
    cyc(1);
    bus_up.start = 1'b1;
    cyc(1);
    bus_up.start = 1'b0;
    cyc(15);
    n_tests++;
    if ({bus_up.tick, bus_up.tens, bus_up.ones} !== {1'b1, 8'h15}) begin
      n_fail++; $display("FAIL pre_reset got tick=%b %h want 1 15", bus_up.tick,
                         {bus_up.tens, bus_up.ones});
    end
    #3;
    resetn = 1'b0;
    #1;
    n_tests++;
    if ({bus_up.tick, bus_up.running, bus_up.done, bus_up.tens, bus_up.ones} !== 11'd0) begin
      n_fail++; $display("FAIL async_reset got tick=%b run=%b done=%b %h want all 0", bus_up.tick,
                         bus_up.running, bus_up.done, {bus_up.tens, bus_up.ones});
    end
    #2;
    resetn = 1'b1;
    cyc(2);
    n_tests++;
    if ({bus_up.tick, bus_up.running, bus_up.done, bus_up.tens, bus_up.ones} !== 11'd0) begin
      n_fail++; $display("FAIL post_reset_idle got tick=%b run=%b done=%b %h want all 0",
                         bus_up.tick, bus_up.running, bus_up.done, {bus_up.tens, bus_up.ones});
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    resetn       = 1'b0;
    bus_up.start = 1'b0;
    bus_up.pause = 1'b0;
    bus_up.clear = 1'b0;
    bus_up.rate  = 2'b00;
    bus_up.down  = 1'b0;
    bus_dn.start = 1'b0;
    bus_dn.pause = 1'b0;
    bus_dn.clear = 1'b0;
    bus_dn.rate  = 2'b00;
    bus_dn.down  = 1'b1;
    test_reset();
    test_down();
    test_up_fast();
    test_rate_slow();
    test_pause();
    test_clear_and_rate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
